ex_wb_pipe: RTL and testbench

Back half of the RV32I pipeline: the EX/MEM and MEM/WB pipeline registers, the data-memory load handshake, load-use hazard detection and the write-back port into the register bank. It produces the EX/MEM and MEM/WB destination, RegWrite and result signals that the forwarding unit and the ID/EX operand muxes consume. It also generates the stall signals that freeze the front of the pipeline.

---
 rtl/ex_wb_pipe.sv | 118 +++++++++++
 tb/tb_ex_wb_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_pipe.sv
// ex_wb_pipe: back half of the RV32I pipeline.
//   Holds the EX/MEM and MEM/WB pipeline registers and sequences the
//   data-memory load handshake. Also flags load-use hazards for ID and
//   counts memory wait cycles.
//
// Ports
//   clk, reset            pipeline clock, synchronous active-high reset
//   ex_valid/rd/regwrite/memread/result   instruction leaving EX
//   id_rs1, id_rs2        source registers of the instruction in ID
//   mem_rdata, mem_ready  load data / completion from data memory
//   mem_req, mem_addr     load pending in EX/MEM and its address
//   EXMEMrd, EXMEM_RegWrite, EXMEM_result   EX/MEM forwarding view
//   MEMWBrd, MEMWB_RegWrite, MEMWB_data     register-bank write port
//   mem_hold              EX/MEM frozen, upstream must hold EX inputs
//   load_use_stall        ID stalls and injects a bubble into EX
//   wait_count            saturating count of mem_hold cycles
//
// MEM-stage FSM
//   state  | meaning
//   S_RUN  | no outstanding load wait; EX/MEM advances unless a load misses
//   S_WAIT | load in EX/MEM waiting on mem_ready; pipeline frozen
module ex_wb_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [4:0]      EXMEMrd,
  output logic            EXMEM_RegWrite,
  output logic [XLEN-1:0] EXMEM_result,
  output logic [4:0]      MEMWBrd,
  output logic            MEMWB_RegWrite,
  output logic [XLEN-1:0] MEMWB_data,
  output logic            mem_hold,
  output logic            load_use_stall,
  output logic [7:0]      wait_count
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t state;
  logic   exmem_valid;
  logic   exmem_memread;

  assign mem_req  = exmem_valid & exmem_memread;
  assign mem_addr = EXMEM_result;
  assign mem_hold = ((state == S_RUN)  & mem_req & ~mem_ready) |
                    ((state == S_WAIT) & ~mem_ready);

  // Combinational so ID sees the hazard in the same cycle the load sits in EX.
  assign load_use_stall = ex_valid & ex_memread & ex_regwrite & (ex_rd != 5'd0) &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
    end else begin
      case (state)
        S_RUN:   if (mem_req & ~mem_ready) state <= S_WAIT;
        S_WAIT:  if (mem_ready) state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  // EX/MEM: rd and RegWrite are cleaned on capture so forwarding can
  // trust them without re-checking valid or rd == x0.
  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_valid    <= 1'b0;
      exmem_memread  <= 1'b0;
      EXMEMrd        <= 5'd0;
      EXMEM_RegWrite <= 1'b0;
      EXMEM_result   <= '0;
    end else if (!mem_hold) begin
      exmem_valid    <= ex_valid;
      exmem_memread  <= ex_valid & ex_memread;
      EXMEMrd        <= ex_valid ? ex_rd : 5'd0;
      EXMEM_RegWrite <= ex_valid & ex_regwrite & (ex_rd != 5'd0);
      EXMEM_result   <= ex_result;
    end
  end

  // MEM/WB: a held cycle produces a bubble but keeps the last data value.
  always_ff @(posedge clk) begin
    if (reset) begin
      MEMWBrd        <= 5'd0;
      MEMWB_RegWrite <= 1'b0;
      MEMWB_data     <= '0;
    end else if (mem_hold) begin
      MEMWBrd        <= 5'd0;
      MEMWB_RegWrite <= 1'b0;
    end else begin
      MEMWBrd        <= EXMEMrd;
      MEMWB_RegWrite <= EXMEM_RegWrite;
      MEMWB_data     <= mem_req ? mem_rdata : EXMEM_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_count <= 8'd0;
    end else if (mem_hold && wait_count != 8'hFF) begin
      wait_count <= wait_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ex_wb_pipe.sv
module tb_ex_wb_pipe;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_regwrite;
  logic            ex_memread;
  logic [XLEN-1:0] ex_result;
  logic [4:0]      id_rs1, id_rs2;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [4:0]      EXMEMrd;
  logic            EXMEM_RegWrite;
  logic [XLEN-1:0] EXMEM_result;
  logic [4:0]      MEMWBrd;
  logic            MEMWB_RegWrite;
  logic [XLEN-1:0] MEMWB_data;
  logic            mem_hold;
  logic            load_use_stall;
  logic [7:0]      wait_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_wb_pipe #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_result(ex_result),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .EXMEMrd(EXMEMrd), .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_result(EXMEM_result),
    .MEMWBrd(MEMWBrd), .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_data(MEMWB_data),
    .mem_hold(mem_hold), .load_use_stall(load_use_stall), .wait_count(wait_count)
  );

  // Reference model: one instruction slot per stage, described by the
  // instruction it holds rather than by any state machine.
  logic            m_ev, m_eload;
  logic [4:0]      m_erd;
  logic            m_erw;
  logic [XLEN-1:0] m_eres;
  logic [4:0]      m_wrd;
  logic            m_wrw;
  logic [XLEN-1:0] m_wdata;
  int              m_wc;

  function automatic logic exp_req();
    return m_ev & m_eload;
  endfunction

  function automatic logic exp_hold();
    return m_ev & m_eload & ~mem_ready;
  endfunction

  function automatic logic exp_lus();
    return ex_valid & ex_memread & ex_regwrite & (ex_rd != 0) &
           ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  endfunction

  // Advance one clock; inputs are driven on the falling edge and stable here.
  task automatic tick();
    logic load_waiting, load_done;
    load_waiting = exp_hold();
    load_done    = exp_req() & mem_ready;
    @(posedge clk);
    if (reset) begin
      m_ev = 0; m_eload = 0; m_erd = 0; m_erw = 0; m_eres = 0;
      m_wrd = 0; m_wrw = 0; m_wdata = 0; m_wc = 0;
    end else if (load_waiting) begin
      m_wrd = 0; m_wrw = 0;
      m_wc = (m_wc < 255) ? m_wc + 1 : 255;
    end else begin
      m_wrd   = m_erd;
      m_wrw   = m_erw;
      m_wdata = load_done ? mem_rdata : m_eres;
      m_ev    = ex_valid;
      m_eload = ex_valid & ex_memread;
      m_erd   = ex_valid ? ex_rd : 5'd0;
      m_erw   = ex_valid & ex_regwrite & (ex_rd != 0);
      m_eres  = ex_result;
    end
    @(negedge clk);
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic rw,
                          input logic ld, input logic [XLEN-1:0] res);
    ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memread = ld; ex_result = res;
  endtask

  task automatic do_reset();
    reset = 1; drive_ex(0, 0, 0, 0, 0); mem_ready = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      reset = 1;
      drive_ex(1, 5'($urandom_range(1, 31)), 1, 0, $urandom);
      mem_ready = 1; mem_rdata = $urandom;
      tick();
      tests_run++;
      if ({mem_req, mem_hold, EXMEMrd, EXMEM_RegWrite, EXMEM_result, MEMWBrd,
           MEMWB_RegWrite, MEMWB_data, wait_count} !== '0) begin
        tests_failed++;
        $display("FAIL reset_state cyc%0d: req=%b hold=%b exrd=%0d exrw=%b exres=%h wbrd=%0d wbrw=%b wbdata=%h wc=%0d required all 0",
                 i, mem_req, mem_hold, EXMEMrd, EXMEM_RegWrite, EXMEM_result, MEMWBrd,
                 MEMWB_RegWrite, MEMWB_data, wait_count);
      end
    end
    reset = 0; drive_ex(0, 0, 0, 0, 0); mem_ready = 0;
  endtask

  task automatic test_alu();
    do_reset();
    drive_ex(1, 5, 1, 0, 32'h12345678);
    mem_ready = 1; mem_rdata = 32'hBAD0BAD0;  // ignored: nothing pending
    tick();
    drive_ex(0, 0, 0, 0, 0);
    tests_run++;
    if (EXMEMrd !== 5 || EXMEM_RegWrite !== 1 || EXMEM_result !== 32'h12345678 || mem_hold !== 0) begin
      tests_failed++;
      $display("FAIL alu_exmem: rd=%0d rw=%b res=%h hold=%b required 5 1 12345678 0",
               EXMEMrd, EXMEM_RegWrite, EXMEM_result, mem_hold);
    end
    tick();
    tests_run++;
    if (MEMWBrd !== 5 || MEMWB_RegWrite !== 1 || MEMWB_data !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL alu_memwb: rd=%0d rw=%b data=%h required 5 1 12345678",
               MEMWBrd, MEMWB_RegWrite, MEMWB_data);
    end
    mem_ready = 0;
  endtask

  task automatic test_x0();
    int bad = 0;
    do_reset();
    drive_ex(1, 0, 1, 0, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_ex(0, 0, 0, 0, 0);
      if (EXMEM_RegWrite !== 0 || MEMWB_RegWrite !== 0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL x0_write: %0d cycles with RegWrite high, required 0", bad);
    end
  endtask

  task automatic test_load_wait();
    int holds = 0, bubbles = 0;
    do_reset();
    drive_ex(1, 7, 1, 1, 32'h40);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_hold === 1 && mem_req === 1 && mem_addr === 32'h40) holds++;
      tick();
      if (MEMWB_RegWrite === 0 && MEMWBrd === 0) bubbles++;
    end
    tests_run++;
    if (holds != 3 || bubbles != 3) begin
      tests_failed++;
      $display("FAIL load_wait_hold: hold_cycles=%0d bubbles=%0d required 3 3", holds, bubbles);
    end
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (mem_hold !== 0) begin
      tests_failed++;
      $display("FAIL load_ready_hold: hold=%b required 0", mem_hold);
    end
    tick();
    mem_ready = 0;
    tests_run++;
    if (MEMWBrd !== 7 || MEMWB_RegWrite !== 1 || MEMWB_data !== 32'hDEADBEEF || wait_count !== 3) begin
      tests_failed++;
      $display("FAIL load_wait_wb: rd=%0d rw=%b data=%h wc=%0d required 7 1 deadbeef 3",
               MEMWBrd, MEMWB_RegWrite, MEMWB_data, wait_count);
    end
  endtask

  task automatic test_load_use();
    logic [4:0] r1 [3] = '{5'd0, 5'd4, 5'd0};
    logic [4:0] r2 [3] = '{5'd3, 5'd4, 5'd0};
    logic [4:0] rd [3] = '{5'd3, 5'd3, 5'd0};
    logic       ex [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_ex(1, rd[i], 1, 1, 32'h80);
      id_rs1 = r1[i]; id_rs2 = r2[i];
      #1;
      tests_run++;
      if (load_use_stall !== ex[i]) begin
        tests_failed++;
        $display("FAIL load_use_%0d: stall=%b required %b", i, load_use_stall, ex[i]);
      end
    end
    drive_ex(0, 0, 0, 0, 0); id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic test_reset_wait();
    int writes = 0;
    do_reset();
    drive_ex(1, 9, 1, 1, 32'h44);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    mem_ready = 0;
    tick(); tick();
    reset = 1; tick(); reset = 0;
    tests_run++;
    if (mem_req !== 0 || mem_hold !== 0 || wait_count !== 0 || EXMEMrd !== 0) begin
      tests_failed++;
      $display("FAIL reset_wait: req=%b hold=%b wc=%0d exrd=%0d required 0 0 0 0",
               mem_req, mem_hold, wait_count, EXMEMrd);
    end
    mem_ready = 1; mem_rdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (MEMWB_RegWrite !== 0) writes++;
    end
    mem_ready = 0;
    tests_run++;
    if (writes != 0) begin
      tests_failed++;
      $display("FAIL reset_wait_nowb: write-backs=%0d required 0", writes);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_ex(1, 2, 1, 1, 32'h100);
    tick();
    drive_ex(1, 3, 1, 1, 32'h200);
    mem_ready = 0;
    tick();
    tests_run++;
    if (EXMEM_result !== 32'h100 || EXMEMrd !== 2) begin
      tests_failed++;
      $display("FAIL b2b_frozen: exres=%h exrd=%0d required 100 2", EXMEM_result, EXMEMrd);
    end
    mem_ready = 1; mem_rdata = 32'h11111111;
    tick();
    tests_run++;
    if (MEMWBrd !== 2 || MEMWB_data !== 32'h11111111 || EXMEM_result !== 32'h200 || EXMEMrd !== 3) begin
      tests_failed++;
      $display("FAIL b2b_first: wbrd=%0d wbdata=%h exres=%h exrd=%0d required 2 11111111 200 3",
               MEMWBrd, MEMWB_data, EXMEM_result, EXMEMrd);
    end
    drive_ex(0, 0, 0, 0, 0);
    mem_rdata = 32'h22222222;
    tick();
    tests_run++;
    if (MEMWBrd !== 3 || MEMWB_RegWrite !== 1 || MEMWB_data !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL b2b_second: wbrd=%0d wbrw=%b wbdata=%h required 3 1 22222222",
               MEMWBrd, MEMWB_RegWrite, MEMWB_data);
    end
    mem_ready = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    drive_ex(1, 1, 1, 1, 32'h8);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    mem_ready = 0;
    for (int i = 0; i < 260; i++) tick();
    tests_run++;
    if (wait_count !== 8'd255 || mem_hold !== 1) begin
      tests_failed++;
      $display("FAIL wait_saturate: wc=%0d hold=%b required 255 1", wait_count, mem_hold);
    end
    mem_ready = 1; tick(); mem_ready = 0;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      if (!exp_hold()) begin
        drive_ex($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
                 $urandom_range(0, 2) == 0, $urandom);
      end
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      mem_ready = $urandom_range(0, 2) != 0; mem_rdata = $urandom;
      #1;
      if (!reset && (mem_req !== exp_req() || mem_hold !== exp_hold() || load_use_stall !== exp_lus())) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_comb cyc%0d: req=%b hold=%b lus=%b required %b %b %b",
                   i, mem_req, mem_hold, load_use_stall, exp_req(), exp_hold(), exp_lus());
      end
      tick();
      if (EXMEMrd !== m_erd || EXMEM_RegWrite !== m_erw || EXMEM_result !== m_eres ||
          mem_addr !== m_eres || MEMWBrd !== m_wrd || MEMWB_RegWrite !== m_wrw ||
          MEMWB_data !== m_wdata || wait_count !== 8'(m_wc)) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_regs cyc%0d: exrd=%0d exrw=%b exres=%h wbrd=%0d wbrw=%b wbdata=%h wc=%0d required %0d %b %h %0d %b %h %0d",
                   i, EXMEMrd, EXMEM_RegWrite, EXMEM_result, MEMWBrd, MEMWB_RegWrite, MEMWB_data,
                   wait_count, m_erd, m_erw, m_eres, m_wrd, m_wrw, m_wdata, m_wc);
      end
    end
    reset = 0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL random_model: %0d mismatching cycles, required 0", bad);
    end
  endtask

  initial begin
    reset = 1; drive_ex(0, 0, 0, 0, 0);
    id_rs1 = 0; id_rs2 = 0; mem_rdata = 0; mem_ready = 0;
    m_ev = 0; m_eload = 0; m_erd = 0; m_erw = 0; m_eres = 0;
    m_wrd = 0; m_wrw = 0; m_wdata = 0; m_wc = 0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_x0();
    test_load_wait();
    test_load_use();
    test_reset_wait();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
